// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolution unit.
// The prediction metadata carried alongside each instruction through ID and EX.
package branch_resolve_unit_pkg;

  localparam int unsigned BRU_XLEN   = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef struct packed {
    logic                v;
    logic                pred_taken;
    logic [BRU_XLEN-1:0] pred_target;
  } pred_meta_t;

  localparam pred_meta_t META_RESET = '0;

endpackage

// File: rtl/bru_perf_counters.sv
// Branch and mispredict event counters; free-running, wrapping, one enable each.
module bru_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_branch,
  input  logic             inc_mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (inc_branch)     branch_count     <= branch_count + CNT_W'(1);
      if (inc_mispredict) mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF-stage predictions through ID/EX, resolves them against the real outcome,
// raises a one-shot redirect on mispredict and trains the predictor a cycle later.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN  = BRU_XLEN,  // must match the slot width in the package
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  pc_if,
  input  logic             pred_taken_if,
  input  logic [XLEN-1:0]  pred_target_if,
  input  logic             stall_id,
  input  logic             stall_ex,
  input  logic             flush_ext,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic             is_branch_ex,
  input  logic             is_jump_ex,
  input  logic             cond_taken_ex,
  input  logic [XLEN-1:0]  target_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_front,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_is_branch,
  output logic             upd_is_jump,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  pred_meta_t      id_q, id_d, ex_q, ex_d;
  logic            resolved_q, resolved_d;
  logic            ex_live, is_cti, actual_taken, mispredict, upd_valid_d;
  logic [XLEN-1:0] seq_pc, actual_next, pred_next;

  // The IF PC is not needed: slots are matched to EX purely by pipeline position.
  logic unused_pc_if;
  assign unused_pc_if = ^pc_if;

  always_comb begin
    ex_live      = ex_valid & ex_q.v;
    is_cti       = is_branch_ex | is_jump_ex;
    seq_pc       = pc_ex + XLEN'(INSN_BYTES);
    actual_taken = is_jump_ex | (is_branch_ex & cond_taken_ex);
    actual_next  = actual_taken ? target_ex : seq_pc;
    pred_next    = (ex_q.v & ex_q.pred_taken) ? ex_q.pred_target : seq_pc;
    mispredict   = ex_live & ~resolved_q & ~flush_ext & (pred_next != actual_next);
    upd_valid_d  = ex_live & is_cti & ~resolved_q & ~flush_ext;
  end

  assign redirect_valid = mispredict;
  assign redirect_pc    = actual_next;
  assign flush_front    = mispredict;

  always_comb begin
    id_d = id_q;
    if (!stall_id) begin
      id_d.v           = if_valid;
      id_d.pred_taken  = pred_taken_if;
      id_d.pred_target = pred_target_if;
    end
    if (flush_ext || mispredict) id_d.v = 1'b0;

    ex_d = ex_q;
    if (!stall_ex) ex_d = id_q;
    if (flush_ext) ex_d.v = 1'b0;

    // Once an instruction held in EX has been resolved, suppress repeat redirect/update.
    resolved_d = resolved_q;
    if (flush_ext || !stall_ex) resolved_d = 1'b0;
    else if (ex_live)           resolved_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q          <= META_RESET;
      ex_q          <= META_RESET;
      resolved_q    <= 1'b0;
      upd_valid     <= 1'b0;
      upd_pc        <= '0;
      upd_taken     <= 1'b0;
      upd_target    <= '0;
      upd_is_branch <= 1'b0;
      upd_is_jump   <= 1'b0;
    end else begin
      id_q       <= id_d;
      ex_q       <= ex_d;
      resolved_q <= resolved_d;
      upd_valid  <= upd_valid_d;
      if (upd_valid_d) begin
        upd_pc        <= pc_ex;
        upd_taken     <= actual_taken;
        upd_target    <= target_ex;
        upd_is_branch <= is_branch_ex;
        upd_is_jump   <= is_jump_ex;
      end
    end
  end

  bru_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .inc_branch       (upd_valid_d),
    .inc_mispredict   (mispredict & (is_cti | ex_q.pred_taken)),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the prediction pipe and resolution rules.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, pred_taken_if, stall_id, stall_ex, flush_ext;
  logic [31:0] pc_if, pred_target_if, pc_ex, target_ex;
  logic        ex_valid, is_branch_ex, is_jump_ex, cond_taken_ex;
  logic        redirect_valid, flush_front, upd_valid, upd_taken, upd_is_branch, upd_is_jump;
  logic [31:0] redirect_pc, upd_pc, upd_target, branch_count, mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue-like view of two pipeline positions, each {valid, taken, target}.
  bit        m_v[2];
  bit        m_t[2];
  bit [31:0] m_tg[2];
  bit        m_res;
  bit        e_redir;
  bit [31:0] e_rpc;
  bit        e_uv, e_ut, e_ub, e_uj;
  bit [31:0] e_upc, e_utg, e_bc, e_mc;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid         (if_valid),
    .pc_if            (pc_if),
    .pred_taken_if    (pred_taken_if),
    .pred_target_if   (pred_target_if),
    .stall_id         (stall_id),
    .stall_ex         (stall_ex),
    .flush_ext        (flush_ext),
    .ex_valid         (ex_valid),
    .pc_ex            (pc_ex),
    .is_branch_ex     (is_branch_ex),
    .is_jump_ex       (is_jump_ex),
    .cond_taken_ex    (cond_taken_ex),
    .target_ex        (target_ex),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_front      (flush_front),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_is_branch    (upd_is_branch),
    .upd_is_jump      (upd_is_jump),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_t[i] = 0; m_tg[i] = 0;
    end
    m_res = 0; e_uv = 0; e_ut = 0; e_ub = 0; e_uj = 0;
    e_upc = 0; e_utg = 0; e_bc = 0; e_mc = 0;
  endtask

  task automatic model_eval();
    bit        taken;
    bit [31:0] fallthrough, actual, predicted;
    fallthrough = pc_ex + 32'd4;
    taken       = is_jump_ex || (is_branch_ex && cond_taken_ex);
    actual      = taken ? target_ex : fallthrough;
    predicted   = (m_v[1] && m_t[1]) ? m_tg[1] : fallthrough;
    e_rpc       = actual;
    e_redir     = ex_valid && m_v[1] && !m_res && !flush_ext && (predicted != actual);
  endtask

  task automatic model_clock();
    bit live;
    live = ex_valid && m_v[1];
    e_uv = live && (is_branch_ex || is_jump_ex) && !m_res && !flush_ext;
    if (e_uv) begin
      e_upc = pc_ex;
      e_ut  = is_jump_ex || (is_branch_ex && cond_taken_ex);
      e_utg = target_ex;
      e_ub  = is_branch_ex;
      e_uj  = is_jump_ex;
      e_bc  = e_bc + 1;
    end
    if (e_redir && (is_branch_ex || is_jump_ex || m_t[1])) e_mc = e_mc + 1;
    if (flush_ext || !stall_ex) m_res = 0;
    else if (live)              m_res = 1;
    if (!stall_ex) begin
      m_v[1] = m_v[0]; m_t[1] = m_t[0]; m_tg[1] = m_tg[0];
    end
    if (flush_ext) m_v[1] = 0;
    if (!stall_id) begin
      m_v[0] = if_valid; m_t[0] = pred_taken_if; m_tg[0] = pred_target_if;
    end
    if (flush_ext || e_redir) m_v[0] = 0;
  endtask

  task automatic idle();
    if_valid = 0; pc_if = 0; pred_taken_if = 0; pred_target_if = 0;
    stall_id = 0; stall_ex = 0; flush_ext = 0;
    ex_valid = 0; pc_ex = 0; is_branch_ex = 0; is_jump_ex = 0; cond_taken_ex = 0;
    target_ex = 0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  // Push one fetched instruction's prediction down into the EX slot.
  task automatic load_to_ex(input bit [31:0] pc, input bit pt, input bit [31:0] tg);
    idle();
    if_valid = 1; pc_if = pc; pred_taken_if = pt; pred_target_if = tg;
    tick();
    if_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    ex_valid = 1; is_jump_ex = 1; pc_ex = 32'h10; target_ex = 32'h80;
    settle();
    vectors++;
    if (redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_redirect: got %0b want 0", redirect_valid);
    end
    vectors++;
    if (upd_valid !== 1'b0 || upd_pc !== 32'h0 || upd_target !== 32'h0 || upd_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_upd: got v=%0b pc=%h tg=%h t=%0b want all 0",
               upd_valid, upd_pc, upd_target, upd_taken);
    end
    vectors++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", branch_count, mispredict_count);
    end
    tick();
  endtask

  task automatic test_beq_mispredict();
    apply_reset();
    load_to_ex(32'h100, 1'b0, 32'h0);
    ex_valid = 1; pc_ex = 32'h100; is_branch_ex = 1; cond_taken_ex = 1; target_ex = 32'h140;
    settle();
    vectors++;
    if (redirect_valid !== 1'b1 || flush_front !== 1'b1 || redirect_pc !== 32'h140) begin
      miscompares++;
      $display("FAIL beq_redirect: got v=%0b ff=%0b pc=%h want 1 1 00000140",
               redirect_valid, flush_front, redirect_pc);
    end
    tick();
    vectors++;
    if (upd_valid !== 1'b1 || upd_taken !== 1'b1 || upd_target !== 32'h140 ||
        upd_pc !== 32'h100 || upd_is_branch !== 1'b1 || upd_is_jump !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_update: got v=%0b t=%0b tg=%h pc=%h b=%0b j=%0b want 1 1 140 100 1 0",
               upd_valid, upd_taken, upd_target, upd_pc, upd_is_branch, upd_is_jump);
    end
    vectors++;
    if (mispredict_count !== 32'd1 || branch_count !== 32'd1) begin
      miscompares++;
      $display("FAIL beq_counts: got b=%0d m=%0d want 1 1", branch_count, mispredict_count);
    end
  endtask

  task automatic test_bne_correct();
    apply_reset();
    load_to_ex(32'h200, 1'b1, 32'h240);
    ex_valid = 1; pc_ex = 32'h200; is_branch_ex = 1; cond_taken_ex = 1; target_ex = 32'h240;
    settle();
    vectors++;
    if (redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL bne_redirect: got %0b want 0", redirect_valid);
    end
    tick();
    vectors++;
    if (upd_valid !== 1'b1 || branch_count !== 32'd1 || mispredict_count !== 32'd0) begin
      miscompares++;
      $display("FAIL bne_update: got v=%0b b=%0d m=%0d want 1 1 0",
               upd_valid, branch_count, mispredict_count);
    end
  endtask

  task automatic test_blt_not_taken();
    apply_reset();
    load_to_ex(32'h300, 1'b1, 32'h380);
    ex_valid = 1; pc_ex = 32'h300; is_branch_ex = 1; cond_taken_ex = 0; target_ex = 32'h380;
    settle();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin
      miscompares++;
      $display("FAIL blt_redirect: got v=%0b pc=%h want 1 00000304", redirect_valid, redirect_pc);
    end
    tick();
    vectors++;
    if (upd_valid !== 1'b1 || upd_taken !== 1'b0 || upd_target !== 32'h380) begin
      miscompares++;
      $display("FAIL blt_update: got v=%0b t=%0b tg=%h want 1 0 00000380",
               upd_valid, upd_taken, upd_target);
    end
  endtask

  task automatic test_btb_alias();
    apply_reset();
    load_to_ex(32'h400, 1'b1, 32'h500);
    ex_valid = 1; pc_ex = 32'h400; target_ex = 32'h500;
    settle();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h404) begin
      miscompares++;
      $display("FAIL alias_redirect: got v=%0b pc=%h want 1 00000404", redirect_valid, redirect_pc);
    end
    tick();
    vectors++;
    if (upd_valid !== 1'b0 || mispredict_count !== 32'd1 || branch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL alias_update: got v=%0b m=%0d b=%0d want 0 1 0",
               upd_valid, mispredict_count, branch_count);
    end
  endtask

  task automatic test_stall_hold();
    int pulses = 0;
    apply_reset();
    load_to_ex(32'h100, 1'b0, 32'h0);
    ex_valid = 1; pc_ex = 32'h100; is_branch_ex = 1; cond_taken_ex = 1; target_ex = 32'h140;
    for (int i = 0; i < 5; i++) begin
      stall_ex = (i < 3);
      settle();
      vectors++;
      if (redirect_valid !== (i == 0)) begin
        miscompares++;
        $display("FAIL stall_redirect[%0d]: got %0b want %0b", i, redirect_valid, (i == 0));
      end
      tick();
      if (upd_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1 || branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
      miscompares++;
      $display("FAIL stall_once: got pulses=%0d b=%0d m=%0d want 1 1 1",
               pulses, branch_count, mispredict_count);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    load_to_ex(32'h600, 1'b0, 32'h0);
    // A predicted-taken instruction sits in IF and must be killed along with EX.
    if_valid = 1; pc_if = 32'h604; pred_taken_if = 1; pred_target_if = 32'h900;
    ex_valid = 1; pc_ex = 32'h600; is_jump_ex = 1; target_ex = 32'h700; flush_ext = 1;
    settle();
    vectors++;
    if (redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_redirect: got %0b want 0", redirect_valid);
    end
    tick();
    vectors++;
    if (upd_valid !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_update: got v=%0b b=%0d m=%0d want 0 0 0",
               upd_valid, branch_count, mispredict_count);
    end
    flush_ext = 0; if_valid = 0;
    settle();
    vectors++;
    if (redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_ex_cleared: got %0b want 0", redirect_valid);
    end
    tick();
    is_jump_ex = 0; pc_ex = 32'h604;
    settle();
    vectors++;
    if (redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_id_cleared: got %0b want 0", redirect_valid);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    load_to_ex(32'h100, 1'b0, 32'h0);
    ex_valid = 1; pc_ex = 32'h100; is_jump_ex = 1; target_ex = 32'h180;
    tick();
    vectors++;
    if (upd_valid !== 1'b1 || mispredict_count !== 32'd1) begin
      miscompares++;
      $display("FAIL midrst_pre: got v=%0b m=%0d want 1 1", upd_valid, mispredict_count);
    end
    #1 rst_n = 0;
    #1;
    vectors++;
    if (upd_valid !== 1'b0 || upd_pc !== 32'h0 || upd_target !== 32'h0 ||
        branch_count !== 32'd0 || mispredict_count !== 32'd0 || redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got v=%0b pc=%h tg=%h b=%0d m=%0d r=%0b want all 0",
               upd_valid, upd_pc, upd_target, branch_count, mispredict_count, redirect_valid);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    int k;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if_valid       = ($urandom_range(0, 3) != 0);
      pc_if          = $urandom & ~32'h3;
      pred_taken_if  = $urandom_range(0, 1);
      pred_target_if = $urandom & 32'hFFFC;
      stall_id       = ($urandom_range(0, 3) == 0);
      stall_ex       = ($urandom_range(0, 3) == 0);
      flush_ext      = ($urandom_range(0, 15) == 0);
      ex_valid       = ($urandom_range(0, 3) != 0);
      pc_ex          = $urandom & 32'hFFFC;
      k              = $urandom_range(0, 3);
      is_branch_ex   = (k < 2);
      is_jump_ex     = (k == 2);
      cond_taken_ex  = $urandom_range(0, 1);
      target_ex      = $urandom_range(0, 1) ? m_tg[1] : ($urandom & 32'hFFFC);
      settle();
      vectors++;
      if (redirect_valid !== e_redir || flush_front !== e_redir || redirect_pc !== e_rpc) begin
        miscompares++;
        $display("FAIL rnd_redirect[%0d]: got v=%0b ff=%0b pc=%h want v=%0b pc=%h",
                 n, redirect_valid, flush_front, redirect_pc, e_redir, e_rpc);
      end
      tick();
      vectors++;
      if (upd_valid !== e_uv) begin
        miscompares++;
        $display("FAIL rnd_upd_valid[%0d]: got %0b want %0b", n, upd_valid, e_uv);
      end
      if (e_uv) begin
        vectors++;
        if (upd_pc !== e_upc || upd_taken !== e_ut || upd_target !== e_utg ||
            upd_is_branch !== e_ub || upd_is_jump !== e_uj) begin
          miscompares++;
          $display("FAIL rnd_payload[%0d]: got %h %0b %h %0b%0b want %h %0b %h %0b%0b", n,
                   upd_pc, upd_taken, upd_target, upd_is_branch, upd_is_jump,
                   e_upc, e_ut, e_utg, e_ub, e_uj);
        end
      end
      vectors++;
      if (branch_count !== e_bc || mispredict_count !== e_mc) begin
        miscompares++;
        $display("FAIL rnd_counts[%0d]: got b=%0d m=%0d want b=%0d m=%0d",
                 n, branch_count, mispredict_count, e_bc, e_mc);
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #3;
    test_reset();
    test_beq_mispredict();
    test_bne_correct();
    test_blt_not_taken();
    test_btb_alias();
    test_stall_hold();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
